// File: rtl/divider_const_pkg.sv
// -----------------------------------------------------------------------------
// divider_const_pkg
// Shared constants and types for the constant divider divider_5_22 and its
// downstream quotient-check / remainder stage divider_5_22_rem_pipe.
//
// Contents:
//   DIVISOR_22   constant divisor
//   CONST_MULTI  reciprocal multiplier used by the upstream approximation
//   BWI1/BWO1    dividend / quotient widths
//   BWR          remainder width (2^BWR > DIVISOR_22)
//   raw_width()  signed width needed for dividend - quot*DIVISOR
//   divres_t     output-side {quot, rem} pair
// -----------------------------------------------------------------------------
package divider_const_pkg;

    localparam int DIVISOR_22 = 22;
    localparam logic [9:0] CONST_MULTI = 10'b0000101111;

    localparam int BWI1 = 5;
    localparam int BWO1 = 5;
    localparam int BWR  = 5;

    // max(bwi, bwo + clog2(div)) + 2: one guard bit for the sign, one so the
    // unsigned product can never alias into the sign bit.
    function automatic int raw_width(input int bwi, input int bwo, input int div);
        int prod_w;
        prod_w = bwo + $clog2(div);
        return ((bwi > prod_w) ? bwi : prod_w) + 2;
    endfunction

    typedef struct packed {
        logic [BWO1-1:0] quot;
        logic [BWR-1:0]  rem;
    } divres_t;

endpackage

// File: rtl/divider_5_22_corr.sv
// -----------------------------------------------------------------------------
// divider_5_22_corr
// Purely combinational one-step quotient correction. Given the signed raw
// remainder (dividend - quot*DIVISOR) and the approximate quotient, produces
// the corrected quotient, the exact remainder and a flag telling whether the
// quotient had to be changed. Reusable for any constant divisor.
//
// Ports:
//   raw_i   signed raw remainder, RAW_W bits
//   quot_i  approximate quotient, BWO1 bits
//   quot_o  corrected quotient (wraps modulo 2^BWO1)
//   rem_o   exact remainder, BWR bits
//   corr_o  1 when quot_o differs from quot_i
// -----------------------------------------------------------------------------
module divider_5_22_corr #(
    parameter int BWO1    = 5,
    parameter int BWR     = 5,
    parameter int RAW_W   = 12,
    parameter int DIVISOR = 22
) (
    input  logic signed [RAW_W-1:0] raw_i,
    input  logic        [BWO1-1:0]  quot_i,
    output logic        [BWO1-1:0]  quot_o,
    output logic        [BWR-1:0]   rem_o,
    output logic                    corr_o
);
    import divider_const_pkg::*;

    localparam logic signed [RAW_W-1:0] DIV_S = RAW_W'(DIVISOR);
    localparam logic        [BWO1-1:0]  ONE_Q = BWO1'(1);

    logic signed [RAW_W-1:0]     rem_full;
    logic        [RAW_W-BWR-1:0] rem_hi_unused;

    // Only a single step is taken; an upstream error beyond +-1 leaves an
    // out-of-range remainder, but the flag still reports the change.
    always_comb begin
        quot_o   = quot_i;
        rem_full = raw_i;
        if (raw_i[RAW_W-1]) begin
            quot_o   = quot_i - ONE_Q;
            rem_full = raw_i + DIV_S;
        end else if (raw_i >= DIV_S) begin
            quot_o   = quot_i + ONE_Q;
            rem_full = raw_i - DIV_S;
        end
        rem_o  = rem_full[BWR-1:0];
        corr_o = (quot_o != quot_i);
    end

    // Upper bits are zero for legal inputs; they are deliberately dropped.
    assign rem_hi_unused = rem_full[RAW_W-1:BWR];

endmodule

// File: rtl/divider_5_22_rem_pipe.sv
// -----------------------------------------------------------------------------
// divider_5_22_rem_pipe
// Two-stage pipelined quotient check and remainder stage placed after the
// constant divider divider_5_22. S1 registers the dividend / approximate
// quotient pair; S2 registers the corrected quotient and exact remainder.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A stage advances when it is empty or its downstream is taking its
// data; in_ready is combinational from out_ready (no skid buffer), which lets
// S2 hand out and reload in the same cycle for full throughput.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake
//   in_dividend, in_quot   dividend and upstream approximate quotient
//   out_valid / out_ready  output handshake
//   out_quot, out_rem      registered exact quotient / remainder
//   corr_sticky            a correction ever occurred since reset
//
// Build option: define DIVIDER_5_22_CORR_STICKY_EN to build the sticky
// correction flag; otherwise corr_sticky is tied to 0.
// -----------------------------------------------------------------------------
module divider_5_22_rem_pipe #(
    parameter int BWI1    = divider_const_pkg::BWI1,
    parameter int BWO1    = divider_const_pkg::BWO1,
    parameter int DIVISOR = divider_const_pkg::DIVISOR_22,
    parameter int BWR     = divider_const_pkg::BWR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BWI1-1:0] in_dividend,
    input  logic [BWO1-1:0] in_quot,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BWO1-1:0] out_quot,
    output logic [BWR-1:0]  out_rem,
    output logic            corr_sticky
);
    import divider_const_pkg::*;

    localparam int RAW_W = raw_width(BWI1, BWO1, DIVISOR);

    // Stage registers
    logic            s1_valid_q, s1_valid_d;
    logic [BWI1-1:0] s1_div_q,   s1_div_d;
    logic [BWO1-1:0] s1_quot_q,  s1_quot_d;
    logic            s2_valid_q, s2_valid_d;
    divres_t         s2_res_q,   s2_res_d;

    logic s1_adv, s2_adv;

    // Raw remainder datapath
    logic        [RAW_W-1:0] prod;
    logic signed [RAW_W-1:0] raw;
    logic        [BWO1-1:0]  corr_quot;
    logic        [BWR-1:0]   corr_rem;
    logic                    corr_flag;

    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign in_ready = s1_adv;

    // Product is unsigned; the difference is taken as signed.
    assign prod = RAW_W'(s1_quot_q) * RAW_W'(DIVISOR);
    assign raw  = $signed(RAW_W'(s1_div_q)) - $signed(prod);

    divider_5_22_corr #(
        .BWO1    (BWO1),
        .BWR     (BWR),
        .RAW_W   (RAW_W),
        .DIVISOR (DIVISOR)
    ) u_corr (
        .raw_i  (raw),
        .quot_i (s1_quot_q),
        .quot_o (corr_quot),
        .rem_o  (corr_rem),
        .corr_o (corr_flag)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_div_d   = s1_div_q;
        s1_quot_d  = s1_quot_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_div_d  = in_dividend;
                s1_quot_d = in_quot;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d.quot = corr_quot;
                s2_res_d.rem  = corr_rem;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_div_q   <= '0;
            s1_quot_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_div_q   <= s1_div_d;
            s1_quot_q  <= s1_quot_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_quot  = s2_res_q.quot;
    assign out_rem   = s2_res_q.rem;

`ifdef DIVIDER_5_22_CORR_STICKY_EN
    logic sticky_q, sticky_d;

    // Sets on the S2 load of a result whose quotient had to be corrected.
    always_comb begin
        sticky_d = sticky_q;
        if (s2_adv && s1_valid_q && corr_flag) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign corr_sticky = sticky_q;
`else
    logic corr_unused;

    assign corr_unused = corr_flag;
    assign corr_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_divider_5_22_rem_pipe.sv
// -----------------------------------------------------------------------------
// tb_divider_5_22_rem_pipe
// Self-checking bench for divider_5_22_rem_pipe. Expected results come from
// plain integer division (d / 22, d % 22); the upstream quotient is either the
// reciprocal-multiply approximation or a deliberately perturbed value.
// -----------------------------------------------------------------------------
module tb_divider_5_22_rem_pipe;

    localparam int DIV = 22;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_dividend;
    logic [4:0] in_quot;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_quot;
    logic [4:0] out_rem;
    logic       corr_sticky;

    divider_5_22_rem_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dividend (in_dividend),
        .in_quot     (in_quot),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .corr_sticky (corr_sticky)
    );

    // ------------------------------------------------------------ scoreboard
    // Entry: {corr, quot[4:0], rem[4:0]}
    logic [10:0] exp_q[$];
    logic        sticky_done;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model(input int d, input int q);
        logic [4:0] eq, er;
        logic       c;
        eq = 5'(d / DIV);
        er = 5'(d % DIV);
        c  = (q != d / DIV);
        return {c, eq, er};
    endfunction

    function automatic logic exp_sticky(input logic s);
`ifdef DIVIDER_5_22_CORR_STICKY_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    // Upstream reciprocal-multiply quotient of divider_5_22
    function automatic logic [4:0] upstream_q(input int d);
        return 5'((d * 47) >> 10);
    endfunction

    // ------------------------------------------------------------ driver
    // Called at a falling edge; drives one cycle, checks any presented result
    // against the head of the expected queue, and returns at the next falling
    // edge.
    task automatic cycle(input bit v, input logic [4:0] d, input logic [4:0] q,
                         input bit ordy, output bit acc, output bit ov, output bit ir);
        logic [10:0] e;
        in_valid    = v;
        in_dividend = d;
        in_quot     = q;
        out_ready   = ordy;
        #1;
        ov  = out_valid;
        ir  = in_ready;
        acc = v && in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q[0];
                chk("out_quot", 32'(out_quot), 32'(e[9:5]));
                chk("out_rem", 32'(out_rem), 32'(e[4:0]));
                chk("corr_sticky", 32'(corr_sticky), 32'(exp_sticky(sticky_done | e[10])));
                if (ordy) begin
                    sticky_done = sticky_done | e[10];
                    void'(exp_q.pop_front());
                end
            end
        end
        if (acc) exp_q.push_back(model(int'(d), int'(q)));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit a, o, r;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(1'b0, 5'd0, 5'd0, 1'b1, a, o, r);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        bit          acc, ov, ir;
        int          idx;
        int          d, q0, off;
        logic [4:0]  dv, qv;

        sticky_done = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_quot     = '0;
        out_ready   = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_quot", 32'(out_quot), 32'd0);
        chk("rst_out_rem", 32'(out_rem), 32'd0);
        chk("rst_sticky", 32'(corr_sticky), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Exhaustive sweep with the real upstream quotient, full throughput.
        for (int i = 0; i < 32; i++) begin
            dv = 5'(i);
            cycle(1'b1, dv, upstream_q(i), 1'b1, acc, ov, ir);
            chk("sweep_accept", 32'(acc), 32'd1);
            chk("sweep_out_valid", 32'(ov), (i >= 2) ? 32'd1 : 32'd0);
        end
        drain();
        chk("sweep_no_corr", 32'(corr_sticky), 32'd0);

        // Backpressure: out_ready low for the first three cycles.
        idx = 0;
        for (int c = 0; c < 30 && idx < 10; c++) begin
            dv = 5'(idx);
            cycle(1'b1, dv, upstream_q(idx), (c >= 3), acc, ov, ir);
            if (c == 2) chk("bp_in_ready_low", 32'(ir), 32'd0);
            if (c == 2) chk("bp_out_valid_held", 32'(ov), 32'd1);
            if (acc) idx++;
        end
        chk("bp_all_sent", 32'(idx), 32'd10);
        drain();

        // Reset with both stages full.
        cycle(1'b1, 5'd30, 5'd0, 1'b0, acc, ov, ir);
        cycle(1'b1, 5'd31, 5'd2, 1'b0, acc, ov, ir);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_quot", 32'(out_quot), 32'd0);
        chk("mid_rst_out_rem", 32'(out_rem), 32'd0);
        chk("mid_rst_sticky", 32'(corr_sticky), 32'd0);
        exp_q.delete();
        sticky_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 5'd27, upstream_q(27), 1'b1, acc, ov, ir);
        chk("post_rst_in_ready", 32'(ir), 32'd1);
        cycle(1'b0, 5'd0, 5'd0, 1'b1, acc, ov, ir);
        chk("post_rst_lat1", 32'(ov), 32'd0);
        cycle(1'b0, 5'd0, 5'd0, 1'b1, acc, ov, ir);
        chk("post_rst_lat2", 32'(ov), 32'd1);
        drain();

        // Random traffic, quotient off by at most one in either direction.
        for (int c = 0; c < 300; c++) begin
            d   = int'($urandom_range(0, 31));
            q0  = d / DIV;
            off = int'($urandom_range(0, 2)) - 1;
            if (q0 == 0 && off < 0) off = 0;
            dv = 5'(d);
            qv = 5'(q0 + off);
            cycle(($urandom_range(0, 3) != 0), dv, qv, ($urandom_range(0, 3) != 0), acc, ov, ir);
        end
        drain();

        // Forced low and forced high quotients.
        cycle(1'b1, 5'd22, 5'd0, 1'b1, acc, ov, ir);
        cycle(1'b1, 5'd21, 5'd1, 1'b1, acc, ov, ir);
        drain();
        chk("forced_sticky", 32'(corr_sticky), 32'(exp_sticky(1'b1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/divider_5_22_rem_pipe.md
Name: divider_5_22_rem_pipe

Overview:
Pipelined quotient-check and remainder stage that sits directly downstream of the constant divider divider_5_22. It accepts the dividend and the multiplier-approximated quotient, computes the exact remainder, corrects the quotient by ±1 if the approximation missed, and hands out a registered quotient/remainder pair. It uses a valid/ready handshake so it can sit between streaming producers and consumers.

Parameters:
BWI1, 5, dividend width (matches the upstream divider input)
BWO1, 5, quotient width (matches the upstream divider output)
DIVISOR, 22, constant divisor (must match the upstream divider)
BWR, 5, remainder width; must satisfy 2^BWR > DIVISOR

Ports:
clk  input  1  single clock, all flops rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  dividend/quotient pair valid
in_ready  output  1  stage can accept the pair this cycle
in_dividend  input  BWI1  original dividend (i1 of the upstream divider)
in_quot  input  BWO1  approximate quotient (o1 of the upstream divider)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_quot  output  BWO1  exact quotient, floor(dividend/DIVISOR)
out_rem  output  BWR  exact remainder, dividend mod DIVISOR
corr_sticky  output  1  sticky flag: a correction ever occurred (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low): all valid bits 0; out_quot, out_rem, corr_sticky 0. Data registers clear to 0. Reset mid-transfer drops in-flight data silently.
- Two register stages, S1 and S2. Each stage advances when it is empty or the stage downstream is taking its data.
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer)
- S1 on in_valid & in_ready:
  - latch the dividend and quotient
  - compute raw = dividend − quot×DIVISOR as a signed value of width max(BWI1, BWO1+clog2(DIVISOR))+2; the product is unsigned, the subtraction is signed
- S2 correction, decided on raw:
  - raw < 0: quot−1, rem = raw+DIVISOR
  - raw ≥ DIVISOR: quot+1, rem = raw−DIVISOR
  - otherwise: pass quot through, rem = raw[BWR−1:0]
  - Only one correction step is applied. An upstream error larger than ±1 is out of contract; the result is undefined, but the flag still sets.
- Quotient ±1 wraps modulo 2^BWO1. This cannot occur for legal inputs.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput: 1 per cycle.
- Stall: while out_valid & !out_ready, out_quot and out_rem hold stable. When both stages are full, in_ready=0.
- Simultaneous accept at S2 and refill from S1 in the same cycle is required: full throughput under continuous out_ready.
- out_quot and out_rem are registered. No combinational path from in_* to out_*.

Optional Feature:
Macro DIVIDER_5_22_CORR_STICKY_EN.
- Defined: corr_sticky sets in the S2 load cycle whose corrected quotient differs from its input quotient. It stays 1 until reset.
- Not defined: corr_sticky is tied to 0 and no flag logic is built. Quotient/remainder correction is always present in both builds.

Decomposition:
- Shared package divider_const_pkg holds:
  - DIVISOR_22 and the corresponding CONST_MULTI (0b0000101111)
  - the width constants BWI1, BWO1, BWR
  - a struct typedef divres_t {quot, rem} used on the output side
- Sub-module divider_5_22_corr: purely combinational S2 correction logic (raw, quot → corrected quot, rem, corr flag). It is reusable for other constant divisors.
- Pipeline registers and handshake live in the top.

Test Plan:
- Exhaustive sweep: dividend 0..31 with in_quot from divider_5_22, out_ready=1 → out_quot = d/22, out_rem = d%22 (d=21 → 0,21; d=22 → 1,0; d=31 → 1,9), corr_sticky stays 0, one result per cycle after 2-cycle latency.
- Forced low quotient: dividend=22, in_quot=0 → out_quot=1, out_rem=0, corr_sticky=1 (feature build) or 0 (non-feature build).
- Forced high quotient: dividend=21, in_quot=1 → out_quot=0, out_rem=21, correction flagged.
- Backpressure: stream 0..9 with out_ready low for 3 cycles mid-stream → in_ready drops after 2 accepts, outputs hold stable, no loss or duplication, order preserved.
- Reset mid-operation: assert rst_n=0 with both stages valid → out_valid, out_quot, out_rem, corr_sticky go 0 immediately (async). After release, in_ready=1 and the first new result appears 2 cycles after acceptance.
